// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types, including the elastic pipe stage state and per-stage payloads
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_OCC_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  destReg;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } ex_mem_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload-plus-halt register with load enable and asynchronous clear
module pipe_slot #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (load) q <= d;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline stage register with optional skid entry,
// synchronous flush and sticky halt tracking
module pipe_stage_elastic
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter bit SKID   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_halt,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_halt,
    output logic                  halted,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    localparam int W = DATA_W + 1;

    pipe_state_t state, nextState;
    logic [W-1:0] mainQ, skidQ, mainD;
    logic mainLoad, skidLoad, accept, take;

    assign in_ready  = (SKID ? state != TWO : (state == EMPTY || out_ready)) && !halted;
    assign out_valid = state != EMPTY;
    assign {out_halt, out_data} = mainQ;
    assign occupancy = state;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    always_comb begin
        nextState = state;
        mainLoad  = 1'b0;
        skidLoad  = 1'b0;
        mainD     = {in_halt, in_data};
        case (state)
            EMPTY: if (accept) begin
                nextState = ONE;
                mainLoad  = 1'b1;
            end
            ONE: begin
                if (accept && take) mainLoad = 1'b1;
                else if (accept && SKID) begin
                    nextState = TWO;
                    skidLoad  = 1'b1;
                end
                else if (take) nextState = EMPTY;
            end
            TWO: if (take) begin
                nextState = ONE;
                mainLoad  = 1'b1;
                mainD     = skidQ;
            end
            default: nextState = EMPTY;
        endcase
        // flush squashes held beats and anything arriving; slot contents are left untouched
        if (flush) begin
            nextState = EMPTY;
            mainLoad  = 1'b0;
            skidLoad  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= EMPTY;
        else state <= nextState;

    always_ff @(posedge CLK or posedge RST)
        if (RST) halted <= 1'b0;
        else if (take && out_halt) halted <= 1'b1;

    pipe_slot #(.W(W)) mainSlot (
        .clk (CLK),
        .rst (RST),
        .load(mainLoad),
        .d   (mainD),
        .q   (mainQ)
    );

    if (SKID) begin : g_skid
        pipe_slot #(.W(W)) skidSlot (
            .clk (CLK),
            .rst (RST),
            .load(skidLoad),
            .d   ({in_halt, in_data}),
            .q   (skidQ)
        );
    end else begin : g_noskid
        assign skidQ = '0;
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed steps against a queue model of the skid stage,
// plus a pass-through-ready instance for the SKID=0 handshake
module tb_pipe_stage_elastic;

    localparam int DW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          inValid = 0, inHalt = 0, flush = 0, outReady = 0;
    logic [DW-1:0] inData = '0;
    logic          inReady, outValid, outHalt, halted;
    logic [DW-1:0] outData;
    logic [1:0]    occupancy;

    logic          bInValid = 0, bOutReady = 0;
    logic [DW-1:0] bInData = '0;
    logic          bInReady, bOutValid, bOutHalt, bHalted;
    logic [DW-1:0] bOutData;
    logic [1:0]    bOcc;

    pipe_stage_elastic #(.DATA_W(DW), .SKID(1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .in_halt(inHalt), .flush(flush), .out_valid(outValid), .out_ready(outReady),
        .out_data(outData), .out_halt(outHalt), .halted(halted), .occupancy(occupancy)
    );

    pipe_stage_elastic #(.DATA_W(DW), .SKID(0)) dutB (
        .CLK(CLK), .RST(RST), .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .in_halt(1'b0), .flush(1'b0), .out_valid(bOutValid), .out_ready(bOutReady),
        .out_data(bOutData), .out_halt(bOutHalt), .halted(bHalted), .occupancy(bOcc)
    );

    int total = 0;
    int bad = 0;
    logic [DW:0] sbq[$];
    logic expHalted = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: model-check at the falling edge, then return just after the rising edge
    task automatic tick();
        logic [DW:0] head;
        logic expReady;
        @(negedge CLK);
        expReady = (sbq.size() < 2) && !expHalted;
        chk("sb_out_valid", {31'b0, outValid}, {31'b0, sbq.size() != 0});
        chk("sb_occupancy", {30'b0, occupancy}, sbq.size());
        chk("sb_in_ready", {31'b0, inReady}, {31'b0, expReady});
        chk("sb_halted", {31'b0, halted}, {31'b0, expHalted});
        if (outReady && sbq.size() != 0) begin
            head = sbq.pop_front();
            chk("sb_data", {16'b0, outData}, {16'b0, head[DW-1:0]});
            chk("sb_halt", {31'b0, outHalt}, {31'b0, head[DW]});
            if (head[DW]) expHalted = 1'b1;
        end
        if (flush) sbq.delete();
        else if (inValid && expReady) sbq.push_back({inHalt, inData});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", {31'b0, outValid}, 0);
        chk("rst_out_data", {16'b0, outData}, 0);
        chk("rst_out_halt", {31'b0, outHalt}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_occ", {30'b0, occupancy}, 0);
        @(posedge CLK);
        #1 RST = 0;
        #1;
        chk("rst_in_ready", {31'b0, inReady}, 1);
        chk("rst_b_in_ready", {31'b0, bInReady}, 1);

        // SKID=0: pass-through ready
        bInValid = 1; bInData = 16'h5; bOutReady = 0;
        tick();
        bInValid = 0;
        #1;
        chk("b_occ_one", {30'b0, bOcc}, 1);
        chk("b_in_ready_blocked", {31'b0, bInReady}, 0);
        chk("b_out_data5", {16'b0, bOutData}, 16'h5);
        bOutReady = 1; bInValid = 1; bInData = 16'h6;
        #1;
        chk("b_in_ready_pass", {31'b0, bInReady}, 1);
        chk("b_out_valid", {31'b0, bOutValid}, 1);
        tick();
        chk("b_out_data6", {16'b0, bOutData}, 16'h6);
        chk("b_occ_still_one", {30'b0, bOcc}, 1);
        bInValid = 0;
        tick();
        chk("b_occ_empty", {30'b0, bOcc}, 0);

        // streaming
        outReady = 1;
        for (int i = 1; i <= 8; i++) begin
            inValid = 1; inData = DW'(i);
            tick();
            chk("stream_occ", {30'b0, occupancy}, 1);
            chk("stream_in_ready", {31'b0, inReady}, 1);
            chk("stream_data", {16'b0, outData}, i);
        end
        inValid = 0;
        tick();
        chk("stream_drained", {30'b0, occupancy}, 0);

        // backpressure into the skid entry
        outReady = 0; inValid = 1; inData = 16'hA;
        tick();
        chk("bp_occ1", {30'b0, occupancy}, 1);
        inData = 16'hB;
        tick();
        chk("bp_occ2", {30'b0, occupancy}, 2);
        chk("bp_in_ready_low", {31'b0, inReady}, 0);
        chk("bp_hold_a", {16'b0, outData}, 16'hA);
        inValid = 0;
        tick();
        chk("bp_still_a", {16'b0, outData}, 16'hA);
        outReady = 1;
        tick();
        chk("bp_then_b", {16'b0, outData}, 16'hB);
        tick();

        // flush in TWO with a beat offered
        outReady = 0; inValid = 1; inData = 16'h11;
        tick();
        inData = 16'h12;
        tick();
        inData = 16'hC; flush = 1;
        tick();
        flush = 0; inValid = 0;
        chk("flush_valid", {31'b0, outValid}, 0);
        chk("flush_occ", {30'b0, occupancy}, 0);
        outReady = 1;
        tick();
        tick();

        // flush in ONE with a take and an accept in the same cycle
        outReady = 0; inValid = 1; inData = 16'h21;
        tick();
        outReady = 1; inData = 16'h22; flush = 1;
        tick();
        flush = 0; inValid = 0;
        chk("flush_take_empty", {31'b0, outValid}, 0);
        tick();

        // halt retires through the stage
        inValid = 1; inData = 16'h7; inHalt = 1;
        tick();
        inValid = 0; inHalt = 0;
        tick();
        chk("halt_set", {31'b0, halted}, 1);
        chk("halt_blocks", {31'b0, inReady}, 0);
        inValid = 1; inData = 16'h8;
        tick();
        inValid = 0; flush = 1;
        tick();
        flush = 0;
        chk("halt_sticky", {31'b0, halted}, 1);
        chk("halt_no_beat", {31'b0, outValid}, 0);

        // asynchronous reset while holding two beats
        RST = 1;
        sbq.delete();
        expHalted = 0;
        @(posedge CLK);
        #1 RST = 0;
        outReady = 0; inValid = 1; inData = 16'h31;
        tick();
        inData = 16'h32;
        tick();
        inValid = 0;
        chk("pre_rst_occ", {30'b0, occupancy}, 2);
        #2 RST = 1;
        #1;
        chk("arst_valid", {31'b0, outValid}, 0);
        chk("arst_data", {16'b0, outData}, 0);
        chk("arst_occ", {30'b0, occupancy}, 0);
        chk("arst_halted", {31'b0, halted}, 0);
        sbq.delete();
        @(posedge CLK);
        #1 RST = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, handshaked pipeline stage register for the MIPS datapath. It is the successor to the fixed-field, enable-only stage latches: any stage boundary (IF/ID through MEM/WB) carries a packed payload of configurable width. Transfers use valid/ready handshakes and a synchronous flush. An optional two-entry skid mode breaks the combinational ready path, and a sticky halt is tracked when a halting instruction retires through the stage.

## Interface

Parameters
- DATA_W, 128: payload width in bits (packed stage fields). Legal range is ≥1.
- SKID, 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects the single-entry register with pass-through ready.

Ports
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  beat is a halt instruction.
- flush  in  1  synchronous squash of all held beats.
- out_valid  out  1  head beat present.
- out_ready  in  1  downstream takes the head beat.
- out_data  out  DATA_W  head payload.
- out_halt  out  1  head beat's halt flag.
- halted  out  1  sticky; a halt beat has left the stage.
- occupancy  out  2  held beats (0–2).

## Operation
- Accept means `in_valid & in_ready`. Take means `out_valid & out_ready`.
- State machine with states EMPTY, ONE, and TWO. TWO exists only when SKID=1.
  - EMPTY: on accept, go to ONE and set main←in.
  - ONE:
    - accept and take: stay in ONE, main←in.
    - accept only: with SKID=1, go to TWO and set skid←in. With SKID=0 this case cannot occur.
    - take only: go to EMPTY.
  - TWO: on take, go to ONE and set main←skid. No accept is possible in TWO.
- `in_ready` depends on the mode:
  - SKID=1: `in_ready = (state != TWO) & !halted`. It is a pure function of registered state.
  - SKID=0: `in_ready = (state == EMPTY | out_ready) & !halted`.
- `out_valid = (state != EMPTY)`. `out_data` and `out_halt` always present the main entry.
- Flush has the highest priority. The next state is EMPTY, and a beat accepted in the flush cycle is discarded. Data registers are not cleared on flush. A take in the flush cycle still completes downstream.
- Halt:
  - `halted` sets on a take with `out_halt=1`.
  - Once set, `halted` stays set until RST. Flush does not clear it.
  - While `halted=1`, `in_ready=0`.
- `occupancy` reads 0 in EMPTY, 1 in ONE, and 2 in TWO.

## Timing
- Reset values: state EMPTY, `out_valid=0`, `out_data=0`, `out_halt=0`, `halted=0`, `occupancy=0`. `in_ready` is 1 after reset in both modes.
- Latency: an accepted beat appears at `out_valid` on the next edge.
- Throughput is one beat per cycle while `out_ready=1`.
- With SKID=1, downstream backpressure reaches `in_ready` one cycle late, and the skid entry absorbs the beat in flight.
- Beats leave in accept order. No beat is ever dropped except by flush.
- `out_data` is stable while `out_valid & !out_ready`.
- RST asserted mid-transfer immediately forces the reset values; any held beats are lost.

## Structure
- `cpu_types_pkg` gains `pipe_state_t` (EMPTY/ONE/TWO, 2-bit enum) and the `PIPE_OCC_W = 2` constant.
- Sub-module `pipe_slot`: a DATA_W+1-bit (payload plus halt) register with load enable and asynchronous reset to 0. It is instantiated once as main and, with SKID=1, once as skid.
- Stage users pack their fields into `in_data` with a per-stage typedef in the package.

## Test plan
1. Streaming, SKID=1: `out_ready=1`, beats 0x1..0x8 on consecutive cycles. Required: outputs 0x1..0x8 one cycle later, `occupancy` constant at 1, `in_ready` always 1.
2. Backpressure, SKID=1: `out_ready=0` during beats 0xA and 0xB. Required: `occupancy` goes 1 then 2, `in_ready` falls after 0xB, `out_data` holds 0xA. Then raise `out_ready`; required output order is 0xA, 0xB.
3. SKID=0: with `out_ready=0` and ONE holding 0x5, `in_ready=0` in the same cycle. Raise `out_ready` with `in_valid` and 0x6; required: take 0x5 and accept 0x6 in one cycle.
4. Flush in TWO with `in_valid=1` (0xC). Required: next cycle `out_valid=0`, `occupancy=0`, and 0xC never appears at the output.
5. Halt: beat 0x7 with `in_halt=1` taken. Required: `halted=1` from the next cycle and `in_ready=0`. A subsequent flush leaves `halted=1`.
6. RST asserted asynchronously mid-cycle while in TWO. Required: immediate `out_valid=0`, `out_data=0`, `occupancy=0`, `halted=0`.
